// File: rtl/challenge_timer.sv
// challenge_timer: round engine for the binary-refinement game.
// Issues a random 8-bit challenge, runs the per-game countdown, judges each
// submission and accumulates a saturating score.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   start        pulse: begin a new game (score cleared, timer reloaded)
//   clear        pulse: abort to idle, clear score and challenge
//   submit       pulse: judge sw against the current challenge
//   sw[7:0]      player's guess
//   chal[7:0]    current challenge
//   chal_valid   challenge is live; a submit now will be judged
//   time_left    seconds remaining in the game
//   time_up      one-cycle pulse when the game ends
//   result_valid one-cycle pulse, judgement available
//   is_correct   last judgement, held until the next one
//   score        correct answers this game, saturating at SCORE_MAX
module challenge_timer #(
   parameter int          GAME_TIME = 20,
   parameter int          TICK_DIV  = 100000000,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          SCORE_MAX = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        clear,
   input  logic        submit,
   input  logic [7:0]  sw,
   output logic [7:0]  chal,
   output logic        chal_valid,
   output logic [5:0]  time_left,
   output logic        time_up,
   output logic        result_valid,
   output logic        is_correct,
   output logic [13:0] score
);

   localparam int          TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   // An all-zero seed would lock the LFSR up forever.
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [13:0] SCORE_TOP = 14'(SCORE_MAX);
   localparam logic [5:0]  GAME_LEN  = 6'(GAME_TIME);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GEN,
      S_PLAY,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [15:0]     lfsr;
   logic [15:0]     lfsr_nxt;
   logic [7:0]      prev_chal, prev_nxt;
   logic [TW-1:0]   tick, tick_nxt;
   logic [7:0]      chal_nxt;
   logic            cv_nxt;
   logic [5:0]      tl_nxt;
   logic            tu_nxt;
   logic            rv_nxt;
   logic            ic_nxt;
   logic [13:0]     score_nxt;
   logic            running;
   logic            wrap;
   logic            expire;
   logic            match;

   // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
   assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

   assign running = (state == S_GEN) || (state == S_PLAY);
   assign wrap    = running && (tick == TICK_LAST);
   assign expire  = wrap && (time_left == 6'd1);
   assign match   = (sw == chal);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Priority: clear > start > expiry > normal state activity (incl. submit).
   always_comb begin
      state_nxt = state;
      prev_nxt  = prev_chal;
      tick_nxt  = tick;
      chal_nxt  = chal;
      cv_nxt    = chal_valid;
      tl_nxt    = time_left;
      tu_nxt    = 1'b0;
      rv_nxt    = 1'b0;
      ic_nxt    = is_correct;
      score_nxt = score;

      if (clear) begin
         state_nxt = S_IDLE;
         score_nxt = '0;
         tl_nxt    = '0;
         cv_nxt    = 1'b0;
         chal_nxt  = '0;
         prev_nxt  = '0;
         tick_nxt  = '0;
      end else if (start) begin
         state_nxt = S_GEN;
         score_nxt = '0;
         tl_nxt    = GAME_LEN;
         tick_nxt  = '0;
         cv_nxt    = 1'b0;
      end else if (expire) begin
         // A submit landing in this cycle is deliberately discarded.
         state_nxt = S_DONE;
         tu_nxt    = 1'b1;
         cv_nxt    = 1'b0;
         tl_nxt    = '0;
         tick_nxt  = '0;
      end else begin
         if (running) begin
            if (wrap) begin
               tick_nxt = '0;
               tl_nxt   = time_left - 6'd1;
            end else begin
               tick_nxt = tick + TW'(1);
            end
         end

         case (state)
            S_GEN: begin
               // Never re-issue the previous challenge; retry next cycle.
               if (lfsr[7:0] != prev_chal) begin
                  chal_nxt  = lfsr[7:0];
                  prev_nxt  = lfsr[7:0];
                  cv_nxt    = 1'b1;
                  state_nxt = S_PLAY;
               end
            end
            S_PLAY: begin
               if (submit) begin
                  ic_nxt    = match;
                  rv_nxt    = 1'b1;
                  cv_nxt    = 1'b0;
                  state_nxt = S_GEN;
                  if (match && (score < SCORE_TOP)) begin
                     score_nxt = score + 14'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr         <= SEED_EFF;
         prev_chal    <= '0;
         tick         <= '0;
         chal         <= '0;
         chal_valid   <= 1'b0;
         time_left    <= '0;
         time_up      <= 1'b0;
         result_valid <= 1'b0;
         is_correct   <= 1'b0;
         score        <= '0;
      end else begin
         lfsr         <= lfsr_nxt;
         prev_chal    <= prev_nxt;
         tick         <= tick_nxt;
         chal         <= chal_nxt;
         chal_valid   <= cv_nxt;
         time_left    <= tl_nxt;
         time_up      <= tu_nxt;
         result_valid <= rv_nxt;
         is_correct   <= ic_nxt;
         score        <= score_nxt;
      end
   end

endmodule

// File: tb/tb_challenge_timer.sv
// Testbench for challenge_timer with TICK_DIV=4, GAME_TIME=3, SCORE_MAX=2.
module tb_challenge_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic        submit = 1'b0;
   logic [7:0]  sw = '0;
   logic [7:0]  chal;
   logic        chal_valid;
   logic [5:0]  time_left;
   logic        time_up;
   logic        result_valid;
   logic        is_correct;
   logic [13:0] score;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   challenge_timer #(
      .GAME_TIME(3),
      .TICK_DIV (4),
      .SEED     (16'hACE1),
      .SCORE_MAX(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .clear       (clear),
      .submit      (submit),
      .sw          (sw),
      .chal        (chal),
      .chal_valid  (chal_valid),
      .time_left   (time_left),
      .time_up     (time_up),
      .result_valid(result_valid),
      .is_correct  (is_correct),
      .score       (score)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, steps every cycle.
   // m_pre holds the value the DUT sampled at the most recent edge.
   logic [15:0] m, m_pre;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m     <= 16'hACE1;
         m_pre <= 16'h0000;
      end else begin
         m_pre <= m;
         m     <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      end
   end

   typedef struct {
      logic       st;
      logic       cl;
      logic       sb;
      logic       ok;
      logic [5:0] tl;
      logic       tu;
      logic       rv;
      logic [13:0] sc;
      int         cv;   // 0/1 expected, 2 = don't care
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic st, cl, sb, ok, input logic [5:0] tl,
                      input logic tu, rv, input logic [13:0] sc, input int cv);
      vec_t v;
      v.st = st; v.cl = cl; v.sb = sb; v.ok = ok;
      v.tl = tl; v.tu = tu; v.rv = rv; v.sc = sc; v.cv = cv;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
      checks++;
      if (act === bad) begin
         errors++;
         $display("FAIL %s: got %0h must differ from %0h", nm, act, bad);
      end
   endtask

   // Call only while chal_valid is low; returns at the negedge right after it rises.
   task automatic wait_cv(input string nm);
      int n = 0;
      while (!chal_valid && n < 6) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!chal_valid) begin
         errors++;
         $display("FAIL %s: chal_valid got 0 expected 1 within 6 cycles", nm);
      end else begin
         chk({nm, "_lfsr"}, 32'(chal), 32'(m_pre[7:0]));
      end
   endtask

   task automatic do_submit(input logic ok);
      sw     = ok ? chal : (chal ^ 8'h01);
      submit = 1'b1;
      @(negedge clk);
      submit = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_chal"}, 32'(chal), 0);
      chk({nm, "_cv"},   32'(chal_valid), 0);
      chk({nm, "_tl"},   32'(time_left), 0);
      chk({nm, "_tu"},   32'(time_up), 0);
      chk({nm, "_rv"},   32'(result_valid), 0);
      chk({nm, "_ic"},   32'(is_correct), 0);
      chk({nm, "_sc"},   32'(score), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c_old;
      int c;

      // Asynchronous reset, before any clock edge.
      #1 rst = 1'b0;
      #2;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Game 1: start, correct, wrong, then saturation.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_tl", 32'(time_left), 3);
      chk("start_cv", 32'(chal_valid), 0);
      chk("start_sc", 32'(score), 0);
      wait_cv("g1_first");
      chk_ne("g1_first_nz", 32'(chal), 0);
      c_old = chal;
      do_submit(1'b1);
      chk("ok1_rv", 32'(result_valid), 1);
      chk("ok1_ic", 32'(is_correct), 1);
      chk("ok1_sc", 32'(score), 1);
      chk("ok1_cv", 32'(chal_valid), 0);
      wait_cv("g1_second");
      chk_ne("g1_new_chal", 32'(chal), 32'(c_old));
      do_submit(1'b0);
      chk("bad_rv", 32'(result_valid), 1);
      chk("bad_ic", 32'(is_correct), 0);
      chk("bad_sc", 32'(score), 1);
      wait_cv("g1_third");
      do_submit(1'b1);
      chk("ok2_ic", 32'(is_correct), 1);
      chk("ok2_sc", 32'(score), 2);
      wait_cv("g1_fourth");
      do_submit(1'b1);
      chk("sat_rv", 32'(result_valid), 1);
      chk("sat_sc", 32'(score), 2);
      @(negedge clk);
      chk("rv_pulse", 32'(result_valid), 0);

      // Game 2: score 1, then a correct submit exactly in the expiry cycle.
      c = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cv("g2_first");
      do_submit(1'b1);
      chk("g2_sc", 32'(score), 1);
      wait_cv("g2_second");
      while (cyc < c + 12) @(negedge clk);
      chk("pre_exp_tl", 32'(time_left), 1);
      chk("pre_exp_tu", 32'(time_up), 0);
      chk("pre_exp_cv", 32'(chal_valid), 1);
      do_submit(1'b1);
      chk("exp_tu", 32'(time_up), 1);
      chk("exp_rv", 32'(result_valid), 0);
      chk("exp_sc", 32'(score), 1);
      chk("exp_tl", 32'(time_left), 0);
      chk("exp_cv", 32'(chal_valid), 0);
      @(negedge clk);
      do_submit(1'b1);
      chk("done_rv", 32'(result_valid), 0);
      chk("done_sc", 32'(score), 1);
      chk("done_tu", 32'(time_up), 0);

      // Table: countdown, expiry with submit, DONE, clear+start collision.
      add(1, 0, 0, 0, 3, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 2, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 2);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tv.size(); i++) begin
         start  = tv[i].st;
         clear  = tv[i].cl;
         submit = tv[i].sb;
         sw     = tv[i].ok ? chal : (chal ^ 8'h01);
         @(negedge clk);
         chk($sformatf("tv%0d_tl", i), 32'(time_left), 32'(tv[i].tl));
         chk($sformatf("tv%0d_tu", i), 32'(time_up), 32'(tv[i].tu));
         chk($sformatf("tv%0d_rv", i), 32'(result_valid), 32'(tv[i].rv));
         chk($sformatf("tv%0d_sc", i), 32'(score), 32'(tv[i].sc));
         if (tv[i].cv != 2)
            chk($sformatf("tv%0d_cv", i), 32'(chal_valid), 32'(tv[i].cv));
      end
      start  = 1'b0;
      clear  = 1'b0;
      submit = 1'b0;
      chk("clear_chal", 32'(chal), 0);

      // Reset asserted mid-PLAY takes effect without a clock edge.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cv("g3_first");
      do_submit(1'b1);
      chk("g3_sc", 32'(score), 1);
      wait_cv("g3_second");
      #2 rst = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
